mem_access_unit: RTL and testbench

- Memory stage sitting directly downstream of the ALU. It consumes the ALU result (effective address, or the final value for non-memory ops) plus store data and memory control from decode.
- Runs a request/acknowledge handshake with the data memory, aligns store byte lanes, and extracts and sign- or zero-extends load data.
- Hands one registered result per retired instruction to writeback, and stalls upstream while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/load_align.sv | 34 +++
 rtl/mem_access_unit.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access stage: control-field layout,
// access sizes, FSM encoding and the alignment rule.
package mem_pkg;

   localparam int MC_LOAD    = 4;
   localparam int MC_STORE   = 3;
   localparam int MC_SIZE_HI = 2;
   localparam int MC_SIZE_LO = 1;
   localparam int MC_UNS     = 0;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   // Size code 2'b11 is treated as a word access throughout the unit.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = lo[0];
         default: mis = (lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      data_o = rdata_i;
      case (size_i)
         SZ_B:    data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SZ_H:    data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: accepts ALU results, runs the data-memory req/ack handshake
// with a bus timeout, and produces one registered writeback per instruction.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        i_Clk_1,
   input  logic        i_RstN_1,
   input  logic        i_Valid_1,
   output logic        o_Ready_1,
   input  logic [31:0] i_ALUResult_32,
   input  logic [31:0] i_StoreData_32,
   input  logic [4:0]  i_MemControl_5,
   input  logic        i_RegWrite_1,
   output logic        o_DMemReq_1,
   output logic        o_DMemWe_1,
   output logic [31:0] o_DMemAddr_32,
   output logic [31:0] o_DMemWData_32,
   output logic [3:0]  o_DMemByteEn_4,
   input  logic        i_DMemAck_1,
   input  logic [31:0] i_DMemRData_32,
   output logic        o_WBValid_1,
   output logic        o_WBRegWrite_1,
   output logic [31:0] o_WBData_32,
   output logic        o_Misaligned_1,
   output logic        o_BusError_1
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           req_q, req_d;
   logic           we_q, we_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [3:0]     be_q, be_d;
   logic [1:0]     lo_q, lo_d;
   logic [1:0]     size_q, size_d;
   logic           uns_q, uns_d;
   logic           wbv_q, wbv_d;
   logic           wbrw_q, wbrw_d;
   logic [31:0]    wbdata_q, wbdata_d;
   logic           mis_q, mis_d;
   logic           berr_q, berr_d;

   logic           mc_load, mc_store;
   logic [1:0]     size_in;
   logic [31:0]    load_val;
   logic           timeout_hit;

   assign mc_load  = i_MemControl_5[MC_LOAD];
   assign mc_store = i_MemControl_5[MC_STORE] & ~mc_load;
   assign size_in  = i_MemControl_5[MC_SIZE_HI:MC_SIZE_LO];

   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        (32'(cnt_q) == 32'(TIMEOUT_CYCLES - 1));

   load_align u_load_align (
      .rdata_i    (i_DMemRData_32),
      .addr_lo_i  (lo_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (load_val)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      lo_d     = lo_q;
      size_d   = size_q;
      uns_d    = uns_q;
      wbv_d    = 1'b0;
      wbrw_d   = 1'b0;
      wbdata_d = 32'h0;
      mis_d    = 1'b0;
      berr_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_Valid_1) begin
               if (!mc_load && !mc_store) begin
                  wbv_d    = 1'b1;
                  wbrw_d   = i_RegWrite_1;
                  wbdata_d = i_ALUResult_32;
               end else if (is_misaligned(size_in, i_ALUResult_32[1:0])) begin
                  mis_d = 1'b1;
               end else begin
                  state_d = ST_REQ;
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  we_d    = mc_store;
                  addr_d  = {i_ALUResult_32[31:2], 2'b00};
                  lo_d    = i_ALUResult_32[1:0];
                  size_d  = size_in;
                  uns_d   = i_MemControl_5[MC_UNS];
                  if (mc_store) begin
                     case (size_in)
                        SZ_B: begin
                           wdata_d = {4{i_StoreData_32[7:0]}};
                           be_d    = 4'b0001 << i_ALUResult_32[1:0];
                        end
                        SZ_H: begin
                           wdata_d = {2{i_StoreData_32[15:0]}};
                           be_d    = i_ALUResult_32[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                           wdata_d = i_StoreData_32;
                           be_d    = 4'b1111;
                        end
                     endcase
                  end else begin
                     wdata_d = 32'h0;
                     be_d    = 4'b1111;
                  end
               end
            end
         end
         ST_REQ: begin
            if (i_DMemAck_1) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               req_d    = 1'b0;
               wbv_d    = 1'b1;
               wbrw_d   = ~we_q;
               wbdata_d = we_q ? 32'h0 : load_val;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               req_d   = 1'b0;
               berr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk_1 or negedge i_RstN_1) begin
      if (!i_RstN_1) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         be_q     <= 4'h0;
         lo_q     <= 2'b00;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         wbv_q    <= 1'b0;
         wbrw_q   <= 1'b0;
         wbdata_q <= 32'h0;
         mis_q    <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         lo_q     <= lo_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         wbv_q    <= wbv_d;
         wbrw_q   <= wbrw_d;
         wbdata_q <= wbdata_d;
         mis_q    <= mis_d;
         berr_q   <= berr_d;
      end
   end

   assign o_Ready_1      = (state_q == ST_IDLE);
   assign o_DMemReq_1    = req_q;
   assign o_DMemWe_1     = we_q;
   assign o_DMemAddr_32  = addr_q;
   assign o_DMemWData_32 = wdata_q;
   assign o_DMemByteEn_4 = be_q;
   assign o_WBValid_1    = wbv_q;
   assign o_WBRegWrite_1 = wbrw_q;
   assign o_WBData_32    = wbdata_q;
   assign o_Misaligned_1 = mis_q;
   assign o_BusError_1   = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an arithmetic
// reference model of loads, stores, alignment and the bus timeout.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic        ready;
   logic [31:0] alu;
   logic [31:0] sdata;
   logic [4:0]  mc;
   logic        regwrite;
   logic        req, we;
   logic [31:0] maddr, mwdata;
   logic [3:0]  mbe;
   logic        ack;
   logic [31:0] rdata;
   logic        wbv, wbrw;
   logic [31:0] wbdata;
   logic        mis, berr;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .i_Clk_1        (clk),
      .i_RstN_1       (rst_n),
      .i_Valid_1      (valid),
      .o_Ready_1      (ready),
      .i_ALUResult_32 (alu),
      .i_StoreData_32 (sdata),
      .i_MemControl_5 (mc),
      .i_RegWrite_1   (regwrite),
      .o_DMemReq_1    (req),
      .o_DMemWe_1     (we),
      .o_DMemAddr_32  (maddr),
      .o_DMemWData_32 (mwdata),
      .o_DMemByteEn_4 (mbe),
      .i_DMemAck_1    (ack),
      .i_DMemRData_32 (rdata),
      .o_WBValid_1    (wbv),
      .o_WBRegWrite_1 (wbrw),
      .o_WBData_32    (wbdata),
      .o_Misaligned_1 (mis),
      .o_BusError_1   (berr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_load(input logic [31:0] rd, input int off, input int sz, input bit uns);
      longint v;
      if (sz == 0) begin
         v = (longint'(rd) >> (8 * off)) % 256;
         if (!uns && v >= 128) v = v - 256;
      end else if (sz == 1) begin
         v = (longint'(rd) >> (16 * (off / 2))) % 65536;
         if (!uns && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(rd);
      end
      return v[31:0];
   endfunction

   function automatic logic [3:0] exp_be(input bit is_store, input int off, input int sz);
      int be;
      if (!is_store || sz >= 2) be = 15;
      else if (sz == 0) be = 1 << off;
      else be = (off >= 2) ? 12 : 3;
      return be[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int sz);
      longint v;
      if (sz == 0) v = (longint'(d) % 256) * 64'h0101_0101;
      else if (sz == 1) v = (longint'(d) % 65536) * 64'h0001_0001;
      else v = longint'(d);
      return v[31:0];
   endfunction

   function automatic bit exp_misaligned(input int off, input int sz);
      if (sz == 0) return 1'b0;
      if (sz == 1) return (off % 2) != 0;
      return off != 0;
   endfunction

   // ack_dly < 0: never acknowledge (timeout expected after 4 REQ cycles)
   task automatic mem_op(input bit ld, input bit st, input int sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int ack_dly);
      bit is_load, is_store, rw;
      int off, ncyc;
      logic [1:0] szb;
      is_load  = ld;
      is_store = st & !ld;
      off      = int'(a[1:0]);
      szb      = sz[1:0];
      rw       = 1'($urandom);
      @(negedge clk);
      valid    = 1'b1;
      mc       = {ld, st, szb, uns};
      alu      = a;
      sdata    = d;
      regwrite = rw;
      ack      = 1'($urandom);
      rdata    = $urandom;
      check("accept_ready", ready, 1);
      @(negedge clk);
      valid = 1'b0;
      ack   = 1'b0;
      if (!is_load && !is_store) begin
         check("alu_wbvalid", wbv, 1);
         check("alu_wbdata", wbdata, a);
         check("alu_wbregwrite", wbrw, rw);
         check("alu_noreq", req, 0);
         return;
      end
      if (exp_misaligned(off, sz)) begin
         check("mis_pulse", mis, 1);
         check("mis_noreq", req, 0);
         check("mis_nowb", wbv, 0);
         check("mis_ready", ready, 1);
         return;
      end
      check("mem_nomis", mis, 0);
      ncyc = (ack_dly < 0) ? 4 : ack_dly + 1;
      for (int k = 0; k < ncyc; k++) begin
         check("req_high", req, 1);
         check("req_notready", ready, 0);
         check("req_addr", maddr, {a[31:2], 2'b00});
         check("req_we", we, is_store);
         check("req_byteen", mbe, exp_be(is_store, off, sz));
         if (is_store) check("req_wdata", mwdata, exp_wdata(d, sz));
         valid = 1'($urandom);
         alu   = $urandom;
         mc    = 5'($urandom);
         if (k == ack_dly) begin
            ack   = 1'b1;
            rdata = rd;
         end
         @(negedge clk);
         valid = 1'b0;
         ack   = 1'b0;
      end
      check("done_noreq", req, 0);
      check("done_ready", ready, 1);
      if (ack_dly < 0) begin
         check("to_buserror", berr, 1);
         check("to_nowb", wbv, 0);
      end else begin
         check("ack_noberr", berr, 0);
         check("ack_wbvalid", wbv, 1);
         check("ack_wbregwrite", wbrw, !is_store);
         check("ack_wbdata", wbdata, is_store ? 32'h0 : exp_load(rd, off, sz, uns));
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      valid    = 1'b0;
      alu      = 32'h0;
      sdata    = 32'h0;
      mc       = 5'h0;
      regwrite = 1'b0;
      ack      = 1'b0;
      rdata    = 32'h0;

      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_req", req, 0);
      check("rst_we", we, 0);
      check("rst_addr", maddr, 0);
      check("rst_wdata", mwdata, 0);
      check("rst_be", mbe, 0);
      check("rst_wbvalid", wbv, 0);
      check("rst_wbrw", wbrw, 0);
      check("rst_wbdata", wbdata, 0);
      check("rst_mis", mis, 0);
      check("rst_berr", berr, 0);
      rst_n = 1'b1;

      // back-to-back non-memory ops
      @(negedge clk);
      valid = 1'b1; mc = 5'h0; regwrite = 1'b1; alu = 32'd1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("stream_wbvalid", wbv, 1);
         check("stream_wbdata", wbdata, i);
         check("stream_ready", ready, 1);
         alu = i + 1;
         if (i == 3) valid = 1'b0;
      end
      @(negedge clk);
      check("stream_end", wbv, 0);

      mem_op(1, 0, 0, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
      mem_op(1, 0, 0, 1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
      mem_op(0, 1, 1, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 2);
      mem_op(1, 0, 2, 0, 32'h0000_3001, 32'h0, 32'h0, 0);
      mem_op(1, 0, 2, 0, 32'h0000_4000, 32'h0, 32'h0, -1);
      mem_op(0, 1, 2, 0, 32'h0000_4004, 32'hDEAD_BEEF, 32'h0, 1);
      mem_op(1, 1, 1, 0, 32'h0000_5006, 32'h1234_5678, 32'hC001_7000, 1);

      // reset while a request is outstanding
      @(negedge clk);
      valid = 1'b1; mc = 5'b10100; alu = 32'h0000_0040;
      @(negedge clk);
      valid = 1'b0;
      check("rstreq_req", req, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstreq_drop", req, 0);
      check("rstreq_ready", ready, 1);
      check("rstreq_nowb", wbv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstreq_nowb2", wbv, 0);
      check("rstreq_noreq", req, 0);
      mem_op(1, 0, 1, 0, 32'h0000_0010, 32'h0, 32'h7FFF_8001, 0);

      for (int n = 0; n < 60; n++) begin
         int kind, dly;
         kind = int'($urandom_range(0, 2));
         dly  = int'($urandom_range(0, 3));
         if (n % 15 == 7) dly = -1;
         mem_op(kind == 1, kind == 2, int'($urandom_range(0, 2)), 1'($urandom),
                $urandom, $urandom, $urandom, dly);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
